// File: rtl/silu_stream_ctrl_pkg.sv
// Shared definitions for the SiLU streaming controller: FSM states and sizing constants.
package silu_stream_ctrl_pkg;

  // Q8.8 activation word width
  localparam int Q_W = 16;

  // Default output FIFO depth (power of two, at least 4)
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/silu_stream_ctrl_if.sv
// Command, SRAM read, SiLU operand/result and output stream signals of the controller.
interface silu_stream_ctrl_if
  import silu_stream_ctrl_pkg::*;
#(
  parameter int AW = 12
) ();

  logic           start;
  logic [AW-1:0]  src_base;
  logic [AW:0]    len;
  logic           busy;
  logic           done;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic [Q_W-1:0] rd_data;
  logic [Q_W-1:0] silu_x;
  logic [Q_W-1:0] silu_y;
  logic           m_valid;
  logic           m_ready;
  logic [Q_W-1:0] m_data;
  logic           m_last;

  // Controller side
  modport slave (
    input  start, src_base, len, rd_data, silu_y, m_ready,
    output busy, done, rd_en, rd_addr, silu_x, m_valid, m_data, m_last
  );

  // Environment side: command source, SRAM, SiLU unit and stream sink
  modport master (
    output start, src_base, len, rd_data, silu_y, m_ready,
    input  busy, done, rd_en, rd_addr, silu_x, m_valid, m_data, m_last
  );

endinterface

// File: rtl/silu_ofifo.sv
// Synchronous first-word-fall-through FIFO holding SiLU results awaiting the output stream.
module silu_ofifo
  import silu_stream_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = Q_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          pop_ok;

  assign pop_ok = pop && !empty;
  assign dout   = mem[rd_ptr_reg];
  assign full   = (count_reg == (PW+1)'(DEPTH));
  assign empty  = (count_reg == '0);
  assign count  = count_reg;

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + (PW+1)'(push) - (PW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/silu_stream_ctrl.sv
// Streams len Q8.8 words from SRAM through an external PWL SiLU unit into a valid/ready output,
// bounding outstanding reads by the output FIFO depth so the FIFO can never overflow.
module silu_stream_ctrl
  import silu_stream_ctrl_pkg::*;
#(
  parameter int AW    = 12,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic               clk,
  input logic               rst,
  silu_stream_ctrl_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 2;

  state_t         state_reg;
  logic [AW-1:0]  base_reg;
  logic [AW:0]    len_reg;
  logic [AW:0]    issued_reg;
  logic [AW:0]    out_cnt_reg;
  logic           v1_reg;
  logic           v2_reg;

  logic [PW:0]    fifo_count;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_push;
  logic [Q_W-1:0] fifo_dout;
  logic [CW-1:0]  credits;
  logic           hs;
  logic           last_issue;
  logic           drained;

  // Credits: reads still in the two-stage pipe plus words already waiting in the FIFO
  assign credits     = CW'(v1_reg) + CW'(v2_reg) + CW'(fifo_count);
  assign hs          = bus.m_valid && bus.m_ready;
  assign fifo_push   = v2_reg && !fifo_full;

  assign bus.rd_en   = (state_reg == RUN) && (issued_reg < len_reg) && (credits < CW'(DEPTH));
  assign bus.rd_addr = base_reg + issued_reg[AW-1:0];
  assign bus.silu_x  = bus.rd_data;
  assign bus.busy    = (state_reg != IDLE);
  assign bus.done    = (state_reg == DONE);
  assign bus.m_valid = !fifo_empty;
  assign bus.m_data  = bus.m_valid ? fifo_dout : '0;
  assign bus.m_last  = bus.m_valid && (out_cnt_reg == len_reg - (AW+1)'(1));

  assign last_issue  = bus.rd_en && (issued_reg == len_reg - (AW+1)'(1));
  // Nothing in flight and the FIFO empties this cycle: credits will be zero next cycle
  assign drained     = !v1_reg && !v2_reg && (fifo_count == (PW+1)'(hs));

  // Control FSM with job registers and the issue/output element counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      base_reg    <= '0;
      len_reg     <= '0;
      issued_reg  <= '0;
      out_cnt_reg <= '0;
    end else begin
      if (bus.rd_en) begin
        issued_reg <= issued_reg + 1'b1;
      end
      if (hs) begin
        out_cnt_reg <= out_cnt_reg + 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            base_reg    <= bus.src_base;
            len_reg     <= bus.len;
            issued_reg  <= '0;
            out_cnt_reg <= '0;
            state_reg   <= (bus.len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (last_issue) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (drained) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Valid pipe tracking SRAM latency (v1) and SiLU latency (v2); cleared so stale silu_y is ignored
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
    end else begin
      v1_reg <= bus.rd_en;
      v2_reg <= v1_reg;
    end
  end

  silu_ofifo #(
    .DEPTH (DEPTH),
    .W     (Q_W)
  ) u_ofifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (bus.silu_y),
    .pop   (hs),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_silu_stream_ctrl.sv
// Self-checking bench: SRAM and PWL SiLU models, a negedge monitor logging DUT activity,
// and a scoreboard of expected words/addresses filled when each job is launched.
module tb_silu_stream_ctrl;

  localparam int AW = 12;

  typedef struct {
    logic [15:0] d;
    logic        l;
    int          c;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0]   sram [4096];
  logic [15:0]   exp_q[$];
  logic [AW-1:0] exp_addr_q[$];

  out_t          out_log[$];
  logic [AW-1:0] addr_log[$];
  int            rd_cyc_log[$];
  int            done_log[$];
  int            start_log[$];
  int            mv_cnt = 0;
  int            stall_err = 0;
  int            cyc = 0;
  logic          prev_stall = 1'b0;
  logic [15:0]   prev_data = '0;

  always #5 clk = ~clk;

  silu_stream_ctrl_if #(.AW(AW)) bus ();

  silu_stream_ctrl #(.AW(AW), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Golden PWL SiLU: 0 at or below -4.0, identity at or above +4.0, linear ramp in between
  function automatic logic [15:0] silu_fn(input logic [15:0] x);
    logic signed [16:0] xs;
    logic signed [16:0] t;
    xs = signed'({x[15], x});
    if (xs <= -17'sd1024) return 16'h0000;
    if (xs >= 17'sd1024) return x;
    t = (xs + 17'sd1024) >>> 1;
    return t[15:0];
  endfunction

  // SRAM (1-cycle read) and SiLU unit (1-cycle result) models
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= sram[bus.rd_addr];
    bus.silu_y <= silu_fn(bus.silu_x);
  end

  // Monitor: log starts, reads, handshakes, done pulses and stall violations
  always @(negedge clk) begin
    if (rst) begin
      if (bus.start && !bus.busy) start_log.push_back(cyc);
      if (bus.rd_en) begin
        addr_log.push_back(bus.rd_addr);
        rd_cyc_log.push_back(cyc);
      end
      if (bus.m_valid) mv_cnt <= mv_cnt + 1;
      if (bus.m_valid && bus.m_ready) out_log.push_back('{bus.m_data, bus.m_last, cyc});
      if (bus.done) done_log.push_back(cyc);
      if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data)) stall_err <= stall_err + 1;
      prev_stall <= bus.m_valid && !bus.m_ready;
      prev_data  <= bus.m_data;
    end else begin
      prev_stall <= 1'b0;
    end
    cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [AW-1:0] base, input int n);
    bus.start    = 1'b1;
    bus.src_base = base;
    bus.len      = (AW+1)'(n);
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic push_exp(input logic [AW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = base + AW'(i);
      exp_q.push_back(silu_fn(sram[a]));
      exp_addr_q.push_back(a);
    end
  endtask

  task automatic wait_done(input int max, output bit ok);
    int n0;
    n0 = done_log.size();
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (done_log.size() > n0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [32:0] outs;
    rst = 1'b0;
    bus.start = 1'b0; bus.src_base = '0; bus.len = '0; bus.m_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    outs = {bus.busy, bus.done, bus.rd_en, bus.m_valid, bus.m_last, bus.rd_addr, bus.m_data};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", outs);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int a0, o0, r0, n;
    bit ok;
    logic [15:0] e;
    for (int i = 0; i < 4; i++) sram[16 + i] = 16'hF000;
    bus.m_ready = 1'b1;
    a0 = addr_log.size(); o0 = out_log.size(); r0 = rd_cyc_log.size();
    push_exp(12'h010, 4);
    go(12'h010, 4);
    wait_done(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done got timeout want done"); end
    checks++;
    if (addr_log.size() - a0 != 4) begin
      errors++; $display("FAIL basic_rd_count got %0d want 4", addr_log.size() - a0);
    end
    for (int i = 0; i < 4; i++) begin
      logic [AW-1:0] ea;
      ea = exp_addr_q.pop_front();
      if (a0 + i < addr_log.size()) begin
        checks++;
        if (addr_log[a0 + i] !== ea) begin
          errors++; $display("FAIL basic_rd_addr[%0d] got %h want %h", i, addr_log[a0 + i], ea);
        end
      end
    end
    n = out_log.size() - o0;
    checks++;
    if (n != 4) begin errors++; $display("FAIL basic_out_count got %0d want 4", n); end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      if (i < n) begin
        checks++;
        if (out_log[o0 + i].d !== e || out_log[o0 + i].l !== (i == 3)) begin
          errors++;
          $display("FAIL basic_out[%0d] got %h/%b want %h/%b", i, out_log[o0 + i].d, out_log[o0 + i].l, e, (i == 3));
        end
      end
    end
    if (n > 0 && rd_cyc_log.size() > r0) begin
      checks++;
      if (out_log[o0].c - rd_cyc_log[r0] != 3) begin
        errors++; $display("FAIL basic_latency got %0d want 3", out_log[o0].c - rd_cyc_log[r0]);
      end
      checks++;
      if (done_log[$] - out_log[$].c != 1) begin
        errors++; $display("FAIL basic_done_delay got %0d want 1", done_log[$] - out_log[$].c);
      end
    end
  endtask

  task automatic test_backpressure();
    int a0, o0, n;
    bit ok;
    logic [15:0] e;
    bus.m_ready = 1'b0;
    a0 = addr_log.size(); o0 = out_log.size();
    push_exp(12'h100, 16);
    go(12'h100, 16);
    repeat (20) tick();
    checks++;
    if (addr_log.size() - a0 != 4) begin
      errors++; $display("FAIL bp_reads_stalled got %0d want 4", addr_log.size() - a0);
    end
    checks++;
    if (bus.rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en_low got %b want 0", bus.rd_en); end
    bus.m_ready = 1'b1;
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_done got timeout want done"); end
    n = out_log.size() - o0;
    checks++;
    if (n != 16) begin errors++; $display("FAIL bp_out_count got %0d want 16", n); end
    for (int i = 0; i < 16; i++) begin
      logic [AW-1:0] ea;
      ea = exp_addr_q.pop_front();
      e = exp_q.pop_front();
      if (a0 + i < addr_log.size()) begin
        checks++;
        if (addr_log[a0 + i] !== ea) begin
          errors++; $display("FAIL bp_rd_addr[%0d] got %h want %h", i, addr_log[a0 + i], ea);
        end
      end
      if (i < n) begin
        checks++;
        if (out_log[o0 + i].d !== e || out_log[o0 + i].l !== (i == 15)) begin
          errors++;
          $display("FAIL bp_out[%0d] got %h/%b want %h/%b", i, out_log[o0 + i].d, out_log[o0 + i].l, e, (i == 15));
        end
      end
    end
  endtask

  task automatic test_zero_len();
    int a0, o0, mv0, d0;
    bit ok;
    bus.m_ready = 1'b1;
    a0 = addr_log.size(); o0 = out_log.size(); mv0 = mv_cnt; d0 = done_log.size();
    go(12'h055, 0);
    wait_done(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_done got timeout want done"); end
    repeat (4) tick();
    if (ok) begin
      checks++;
      if (done_log[$] - start_log[$] != 1) begin
        errors++; $display("FAIL zero_done_delay got %0d want 1", done_log[$] - start_log[$]);
      end
    end
    checks++;
    if (done_log.size() - d0 != 1) begin
      errors++; $display("FAIL zero_done_pulses got %0d want 1", done_log.size() - d0);
    end
    checks++;
    if (addr_log.size() != a0 || out_log.size() != o0 || mv_cnt != mv0) begin
      errors++;
      $display("FAIL zero_activity got reads %0d valids %0d want 0 0", addr_log.size() - a0, mv_cnt - mv0);
    end
  endtask

  task automatic test_wrap();
    int a0, o0, n;
    bit ok;
    logic [15:0] e;
    bus.m_ready = 1'b1;
    a0 = addr_log.size(); o0 = out_log.size();
    push_exp(12'hFFE, 4);
    go(12'hFFE, 4);
    wait_done(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_done got timeout want done"); end
    n = out_log.size() - o0;
    for (int i = 0; i < 4; i++) begin
      logic [AW-1:0] ea;
      ea = exp_addr_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (a0 + i >= addr_log.size() || addr_log[a0 + i] !== ea) begin
        errors++;
        $display("FAIL wrap_rd_addr[%0d] got %h want %h", i, (a0 + i < addr_log.size()) ? addr_log[a0 + i] : 12'h0, ea);
      end
      checks++;
      if (i >= n || out_log[o0 + i].d !== e) begin
        errors++;
        $display("FAIL wrap_out[%0d] got %h want %h", i, (i < n) ? out_log[o0 + i].d : 16'h0, e);
      end
    end
  endtask

  task automatic test_reset_midjob();
    int a0, o0, d0, n;
    bit ok;
    logic [32:0] outs;
    logic [15:0] e;
    bus.m_ready = 1'b1;
    a0 = addr_log.size();
    go(12'h200, 10);
    for (int i = 0; i < 40; i++) begin
      if (addr_log.size() - a0 >= 5) break;
      tick();
    end
    checks++;
    if (addr_log.size() - a0 != 5) begin
      errors++; $display("FAIL rstmid_reads got %0d want 5", addr_log.size() - a0);
    end
    rst = 1'b0;
    tick();
    @(negedge clk);
    outs = {bus.busy, bus.done, bus.rd_en, bus.m_valid, bus.m_last, bus.rd_addr, bus.m_data};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL rstmid_outputs got %h want 0", outs); end
    tick();
    rst = 1'b1;
    d0 = done_log.size();
    repeat (6) tick();
    checks++;
    if (done_log.size() != d0 || bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_done got %0d/%b want 0/0", done_log.size() - d0, bus.m_valid);
    end
    o0 = out_log.size();
    push_exp(12'h300, 2);
    go(12'h300, 2);
    wait_done(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_restart_done got timeout want done"); end
    n = out_log.size() - o0;
    checks++;
    if (n != 2) begin errors++; $display("FAIL rstmid_out_count got %0d want 2", n); end
    for (int i = 0; i < 2; i++) begin
      void'(exp_addr_q.pop_front());
      e = exp_q.pop_front();
      if (i < n) begin
        checks++;
        if (out_log[o0 + i].d !== e || out_log[o0 + i].l !== (i == 1)) begin
          errors++;
          $display("FAIL rstmid_out[%0d] got %h/%b want %h/%b", i, out_log[o0 + i].d, out_log[o0 + i].l, e, (i == 1));
        end
      end
    end
  endtask

  task automatic test_random_ready();
    int o0, s0, n, d0;
    bit ok;
    logic [15:0] e;
    o0 = out_log.size(); s0 = stall_err; d0 = done_log.size();
    push_exp(12'h400, 100);
    go(12'h400, 100);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      tick();
      if (done_log.size() > d0) begin
        ok = 1'b1;
        break;
      end
    end
    bus.m_ready = 1'b1;
    checks++;
    if (!ok) begin errors++; $display("FAIL rand_done got timeout want done"); end
    n = out_log.size() - o0;
    checks++;
    if (n != 100) begin errors++; $display("FAIL rand_out_count got %0d want 100", n); end
    checks++;
    if (stall_err != s0) begin errors++; $display("FAIL rand_stall_stable got %0d want 0", stall_err - s0); end
    for (int i = 0; i < 100; i++) begin
      void'(exp_addr_q.pop_front());
      e = exp_q.pop_front();
      if (i < n) begin
        checks++;
        if (out_log[o0 + i].d !== e || out_log[o0 + i].l !== (i == 99)) begin
          errors++;
          $display("FAIL rand_out[%0d] got %h/%b want %h/%b", i, out_log[o0 + i].d, out_log[o0 + i].l, e, (i == 99));
        end
      end
    end
  endtask

  initial begin
    // Small signed values around the ramp region, full-range values elsewhere
    for (int i = 0; i < 4096; i++) begin
      if (i >= 'h100 && i < 'h500) sram[i] = 16'($urandom_range(0, 4095)) - 16'd2048;
      else sram[i] = 16'($urandom);
    end
    bus.start = 1'b0;
    bus.src_base = '0;
    bus.len = '0;
    bus.m_ready = 1'b0;

    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_reset_midjob();
    test_random_ready();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
